// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcodes,
// datapath select codes and the packed control-output bundle.
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4,
      S_EXC = 3'd5
   } state_t;

   localparam logic [5:0] OP_RTYPE     = 6'h00;
   localparam logic [5:0] OP_J         = 6'h02;
   localparam logic [5:0] OP_JAL       = 6'h03;
   localparam logic [5:0] OP_BEQ       = 6'h04;
   localparam logic [5:0] OP_BNE       = 6'h05;
   localparam logic [5:0] OP_IARITH_LO = 6'h08;
   localparam logic [5:0] OP_IARITH_HI = 6'h0F;
   localparam logic [5:0] OP_LW        = 6'h23;
   localparam logic [5:0] OP_SW        = 6'h2B;

   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_JALR = 6'h09;

   localparam logic [1:0] REGDST_RT  = 2'b00;
   localparam logic [1:0] REGDST_RD  = 2'b01;
   localparam logic [1:0] REGDST_RA  = 2'b10;
   localparam logic [1:0] REGDST_EXC = 2'b11;

   localparam logic [2:0] PCSRC_PC4    = 3'b000;
   localparam logic [2:0] PCSRC_BRANCH = 3'b001;
   localparam logic [2:0] PCSRC_JUMP   = 3'b010;
   localparam logic [2:0] PCSRC_RS     = 3'b011;
   localparam logic [2:0] PCSRC_EXC    = 3'b100;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_IMM   = 2'b11;

   localparam logic [1:0] ALUSRCB_RT     = 2'b00;
   localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
   localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
   localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

   localparam logic [1:0] MEMTOREG_ALU = 2'b00;
   localparam logic [1:0] MEMTOREG_MDR = 2'b01;
   localparam logic [1:0] MEMTOREG_PC  = 2'b10;

   // Register written by REGDST_EXC ($k0).
   localparam int unsigned EXC_LINK_REG = 26;

   typedef struct packed {
      logic rtype;
      logic iarith;
      logic load;
      logic store;
      logic branch;
      logic branch_ne;
      logic jump;
      logic link;
      logic jr;
      logic illegal;
   } insn_class_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic [2:0] pc_source;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       exception;
   } ctrl_out_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/datapath/memory signal bundle for multicycle_ctrl; the master side
// is the controller, the slave side is the datapath and memory.
interface multicycle_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   import multicycle_ctrl_pkg::*;

   logic [5:0]       OpCode;
   logic [5:0]       Funct;
   logic             Zero;
   logic             MemReady;
   logic             MemReq;
   logic             MemRead;
   logic             MemWrite;
   logic             IorD;
   logic             IRWrite;
   logic             PCWrite;
   logic [2:0]       PCSource;
   logic             RegWrite;
   logic [1:0]       RegDst;
   logic [1:0]       MemtoReg;
   logic             ALUSrcA;
   logic [1:0]       ALUSrcB;
   logic [1:0]       ALUOp;
   logic             Exception;
   logic [CNT_W-1:0] Retired;

   modport master (
      input  OpCode, Funct, Zero, MemReady,
      output MemReq, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource,
             RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, Exception, Retired
   );

   modport slave (
      output OpCode, Funct, Zero, MemReady,
      input  MemReq, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource,
             RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, Exception, Retired
   );

endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational classification of OpCode/Funct into instruction-class flags.
module multicycle_ctrl_decode
   import multicycle_ctrl_pkg::*;
(
   input  logic [5:0]  opcode_i,
   input  logic [5:0]  funct_i,
   output insn_class_t cls_o
);

   logic is_rtype, is_iarith, is_load, is_store, is_branch, is_jump;

   always_comb begin
      is_rtype  = (opcode_i == OP_RTYPE);
      is_iarith = (opcode_i >= OP_IARITH_LO) && (opcode_i <= OP_IARITH_HI);
      is_load   = (opcode_i == OP_LW);
      is_store  = (opcode_i == OP_SW);
      is_branch = (opcode_i == OP_BEQ) || (opcode_i == OP_BNE);
      is_jump   = (opcode_i == OP_J) || (opcode_i == OP_JAL);

      cls_o           = '0;
      cls_o.rtype     = is_rtype;
      cls_o.iarith    = is_iarith;
      cls_o.load      = is_load;
      cls_o.store     = is_store;
      cls_o.branch    = is_branch;
      cls_o.branch_ne = (opcode_i == OP_BNE);
      cls_o.jump      = is_jump;
      // jr covers both register jumps; link marks jal and jalr.
      cls_o.jr        = is_rtype && ((funct_i == FN_JR) || (funct_i == FN_JALR));
      cls_o.link      = (opcode_i == OP_JAL) || (is_rtype && (funct_i == FN_JALR));
      cls_o.illegal   = ~(is_rtype | is_iarith | is_load | is_store | is_branch | is_jump);
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: IF/ID/EX/MEM/WB sequencing, memory handshake,
// illegal-opcode trap and retired-instruction counter.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int unsigned EXC_EN = 1,
   parameter int unsigned CNT_W  = 32
) (
   input logic              clk,
   input logic              reset,
   multicycle_ctrl_if.master ctrl_bus
);

   state_t           state_q, state_d;
   insn_class_t      cls;
   ctrl_out_t        out_d, out_gated;
   logic             retire;
   logic [CNT_W-1:0] retired_q;

   multicycle_ctrl_decode u_decode (
      .opcode_i (ctrl_bus.OpCode),
      .funct_i  (ctrl_bus.Funct),
      .cls_o    (cls)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IF;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      out_d   = '0;
      retire  = 1'b0;
      case (state_q)
         S_IF: begin
            out_d.mem_req   = 1'b1;
            out_d.mem_read  = 1'b1;
            out_d.alu_src_b = ALUSRCB_FOUR;
            out_d.alu_op    = ALUOP_ADD;
            if (ctrl_bus.MemReady) begin
               out_d.ir_write  = 1'b1;
               out_d.pc_write  = 1'b1;
               out_d.pc_source = PCSRC_PC4;
               state_d         = S_ID;
            end
         end
         S_ID: begin
            out_d.alu_src_b = ALUSRCB_IMM_SH;
            out_d.alu_op    = ALUOP_ADD;
            state_d = (cls.illegal && (EXC_EN != 0)) ? S_EXC : S_EX;
         end
         S_EX: begin
            if (cls.rtype) begin
               out_d.alu_src_a = 1'b1;
               out_d.alu_src_b = ALUSRCB_RT;
               out_d.alu_op    = ALUOP_FUNCT;
               if (cls.jr) begin
                  out_d.pc_write  = 1'b1;
                  out_d.pc_source = PCSRC_RS;
                  if (cls.link) begin
                     out_d.reg_write  = 1'b1;
                     out_d.reg_dst    = REGDST_RD;
                     out_d.mem_to_reg = MEMTOREG_PC;
                  end
                  state_d = S_IF;
                  retire  = 1'b1;
               end else begin
                  state_d = S_WB;
               end
            end else if (cls.iarith) begin
               out_d.alu_src_a = 1'b1;
               out_d.alu_src_b = ALUSRCB_IMM;
               out_d.alu_op    = ALUOP_IMM;
               state_d         = S_WB;
            end else if (cls.load || cls.store) begin
               out_d.alu_src_a = 1'b1;
               out_d.alu_src_b = ALUSRCB_IMM;
               out_d.alu_op    = ALUOP_ADD;
               state_d         = S_MEM;
            end else if (cls.branch) begin
               out_d.alu_src_a = 1'b1;
               out_d.alu_src_b = ALUSRCB_RT;
               out_d.alu_op    = ALUOP_SUB;
               out_d.pc_source = PCSRC_BRANCH;
               out_d.pc_write  = cls.branch_ne ? ~ctrl_bus.Zero : ctrl_bus.Zero;
               state_d         = S_IF;
               retire          = 1'b1;
            end else if (cls.jump) begin
               out_d.pc_write  = 1'b1;
               out_d.pc_source = PCSRC_JUMP;
               if (cls.link) begin
                  out_d.reg_write  = 1'b1;
                  out_d.reg_dst    = REGDST_RA;
                  out_d.mem_to_reg = MEMTOREG_PC;
               end
               state_d = S_IF;
               retire  = 1'b1;
            end else begin
               // Untrapped illegal opcode retires as a NOP.
               state_d = S_IF;
               retire  = 1'b1;
            end
         end
         S_MEM: begin
            out_d.mem_req   = 1'b1;
            out_d.iord      = 1'b1;
            out_d.mem_read  = cls.load;
            out_d.mem_write = cls.store;
            if (ctrl_bus.MemReady) begin
               if (cls.load) begin
                  state_d = S_WB;
               end else begin
                  state_d = S_IF;
                  retire  = 1'b1;
               end
            end
         end
         S_WB: begin
            out_d.reg_write  = 1'b1;
            out_d.reg_dst    = cls.rtype ? REGDST_RD : REGDST_RT;
            out_d.mem_to_reg = cls.load ? MEMTOREG_MDR : MEMTOREG_ALU;
            state_d          = S_IF;
            retire           = 1'b1;
         end
         S_EXC: begin
            out_d.exception  = 1'b1;
            out_d.reg_write  = 1'b1;
            out_d.reg_dst    = REGDST_EXC;
            out_d.mem_to_reg = MEMTOREG_PC;
            out_d.pc_write   = 1'b1;
            out_d.pc_source  = PCSRC_EXC;
            state_d          = S_IF;
         end
         default: state_d = S_IF;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retired_q <= '0;
      end else if (retire) begin
         retired_q <= retired_q + CNT_W'(1);
      end
   end

   // Outputs are forced low for as long as reset is held, not just after the edge.
   assign out_gated = reset ? '0 : out_d;

   assign ctrl_bus.MemReq    = out_gated.mem_req;
   assign ctrl_bus.MemRead   = out_gated.mem_read;
   assign ctrl_bus.MemWrite  = out_gated.mem_write;
   assign ctrl_bus.IorD      = out_gated.iord;
   assign ctrl_bus.IRWrite   = out_gated.ir_write;
   assign ctrl_bus.PCWrite   = out_gated.pc_write;
   assign ctrl_bus.PCSource  = out_gated.pc_source;
   assign ctrl_bus.RegWrite  = out_gated.reg_write;
   assign ctrl_bus.RegDst    = out_gated.reg_dst;
   assign ctrl_bus.MemtoReg  = out_gated.mem_to_reg;
   assign ctrl_bus.ALUSrcA   = out_gated.alu_src_a;
   assign ctrl_bus.ALUSrcB   = out_gated.alu_src_b;
   assign ctrl_bus.ALUOp     = out_gated.alu_op;
   assign ctrl_bus.Exception = out_gated.exception;
   assign ctrl_bus.Retired   = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: two instances (trap / NOP on illegal opcode,
// narrow counter) run in lockstep against a per-instruction cycle-list model.
module tb_multicycle_ctrl;

   typedef struct packed {
      logic       mem_req;
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic [2:0] pc_source;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       exception;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   multicycle_ctrl_if #(.CNT_W(32)) bus0 ();
   multicycle_ctrl_if #(.CNT_W(3))  bus1 ();

   multicycle_ctrl #(.EXC_EN(1), .CNT_W(32)) dut0 (
      .clk      (clk),
      .reset    (reset),
      .ctrl_bus (bus0.master)
   );

   multicycle_ctrl #(.EXC_EN(0), .CNT_W(3)) dut1 (
      .clk      (clk),
      .reset    (reset),
      .ctrl_bus (bus1.master)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   bit          chk_en = 1'b0;
   exp_t        exp0, exp1, act0, act1;
   int unsigned ret0 = 0;
   int unsigned ret1 = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         act0.mem_req = bus0.MemReq;     act0.mem_read = bus0.MemRead;
         act0.mem_write = bus0.MemWrite; act0.iord = bus0.IorD;
         act0.ir_write = bus0.IRWrite;   act0.pc_write = bus0.PCWrite;
         act0.pc_source = bus0.PCSource; act0.reg_write = bus0.RegWrite;
         act0.reg_dst = bus0.RegDst;     act0.mem_to_reg = bus0.MemtoReg;
         act0.alu_src_a = bus0.ALUSrcA;  act0.alu_src_b = bus0.ALUSrcB;
         act0.alu_op = bus0.ALUOp;       act0.exception = bus0.Exception;
         act1.mem_req = bus1.MemReq;     act1.mem_read = bus1.MemRead;
         act1.mem_write = bus1.MemWrite; act1.iord = bus1.IorD;
         act1.ir_write = bus1.IRWrite;   act1.pc_write = bus1.PCWrite;
         act1.pc_source = bus1.PCSource; act1.reg_write = bus1.RegWrite;
         act1.reg_dst = bus1.RegDst;     act1.mem_to_reg = bus1.MemtoReg;
         act1.alu_src_a = bus1.ALUSrcA;  act1.alu_src_b = bus1.ALUSrcB;
         act1.alu_op = bus1.ALUOp;       act1.exception = bus1.Exception;
         checks++;
         if (act0 !== exp0) begin
            errors++;
            $display("FAIL outputs_exc t=%0t act=%h exp=%h", $time, act0, exp0);
         end
         checks++;
         if (act1 !== exp1) begin
            errors++;
            $display("FAIL outputs_nop t=%0t act=%h exp=%h", $time, act1, exp1);
         end
         checks++;
         if (bus0.Retired !== ret0) begin
            errors++;
            $display("FAIL retired_exc t=%0t act=%0d exp=%0d", $time, bus0.Retired, ret0);
         end
         checks++;
         if (bus1.Retired !== ret1[2:0]) begin
            errors++;
            $display("FAIL retired_nop t=%0t act=%0d exp=%0d", $time, bus1.Retired, ret1[2:0]);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s t=%0t act=%0d exp=%0d", name, $time, act, exp_v);
      end
   endtask

   task automatic set_insn(input logic [5:0] op, input logic [5:0] fn, input logic z);
      bus0.OpCode = op; bus1.OpCode = op;
      bus0.Funct  = fn; bus1.Funct  = fn;
      bus0.Zero   = z;  bus1.Zero   = z;
   endtask

   // One clock: drive MemReady, publish expectations, then account retirements.
   task automatic cycle(input logic rdy, input exp_t e0, input exp_t e1,
                        input bit r0, input bit r1);
      bus0.MemReady = rdy;
      bus1.MemReady = rdy;
      exp0   = e0;
      exp1   = e1;
      chk_en = 1'b1;
      @(posedge clk);
      if (r0) ret0++;
      if (r1) ret1 = (ret1 + 1) % 8;
      #1;
   endtask

   // Expected cycle list for one instruction, built from the instruction's class.
   task automatic run_insn(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int if_stall, input int mem_stall, input logic idle_rdy);
      exp_t f, e, x;
      bit   rt, jr_like, ia, ld, st, br, jp, illegal, fin;
      set_insn(op, fn, z);
      rt      = (op == 6'h00);
      jr_like = rt && (fn == 6'h08 || fn == 6'h09);
      ia      = (op >= 6'h08) && (op <= 6'h0F);
      ld      = (op == 6'h23);
      st      = (op == 6'h2B);
      br      = (op == 6'h04) || (op == 6'h05);
      jp      = (op == 6'h02) || (op == 6'h03);
      illegal = !(rt || ia || ld || st || br || jp);

      f = '0; f.mem_req = 1; f.mem_read = 1; f.alu_src_b = 2'b01;
      repeat (if_stall) cycle(1'b0, f, f, 0, 0);
      f.ir_write = 1; f.pc_write = 1;
      cycle(1'b1, f, f, 0, 0);

      e = '0; e.alu_src_b = 2'b11;
      cycle(idle_rdy, e, e, 0, 0);

      if (illegal) begin
         x = '0; x.exception = 1; x.reg_write = 1; x.reg_dst = 2'b11;
         x.mem_to_reg = 2'b10; x.pc_write = 1; x.pc_source = 3'b100;
         cycle(idle_rdy, x, '0, 0, 1);
         return;
      end

      e = '0;
      if (rt) begin
         e.alu_src_a = 1; e.alu_op = 2'b10;
         if (jr_like) begin
            e.pc_write = 1; e.pc_source = 3'b011;
            if (fn == 6'h09) begin
               e.reg_write = 1; e.reg_dst = 2'b01; e.mem_to_reg = 2'b10;
            end
         end
      end else if (ia) begin
         e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = 2'b11;
      end else if (ld || st) begin
         e.alu_src_a = 1; e.alu_src_b = 2'b10;
      end else if (br) begin
         e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_source = 3'b001;
         e.pc_write = (op == 6'h05) ? !z : z;
      end else begin
         e.pc_write = 1; e.pc_source = 3'b010;
         if (op == 6'h03) begin
            e.reg_write = 1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10;
         end
      end
      fin = jr_like || br || jp;
      cycle(idle_rdy, e, e, fin, fin);
      if (fin) return;

      if (ld || st) begin
         e = '0; e.mem_req = 1; e.iord = 1; e.mem_read = ld; e.mem_write = st;
         repeat (mem_stall) cycle(1'b0, e, e, 0, 0);
         cycle(1'b1, e, e, st, st);
         if (st) return;
      end

      e = '0; e.reg_write = 1;
      e.reg_dst    = rt ? 2'b01 : 2'b00;
      e.mem_to_reg = ld ? 2'b01 : 2'b00;
      cycle(idle_rdy, e, e, 1, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog t=%0t act=running exp=finished", $time);
      $fatal(1, "timeout");
   end

   initial begin
      exp_t f, e;
      set_insn(6'h00, 6'h00, 1'b0);
      cycle(1'b0, '0, '0, 0, 0);
      cycle(1'b1, '0, '0, 0, 0);
      reset = 1'b0;

      run_insn(6'h00, 6'h20, 1'b0, 0, 0, 1'b1);   // add
      chk("add_retired", bus0.Retired, 32'd1);
      run_insn(6'h23, 6'h00, 1'b0, 0, 3, 1'b1);   // lw, 3 stalls
      chk("lw_retired", bus0.Retired, 32'd2);
      run_insn(6'h04, 6'h00, 1'b1, 0, 0, 1'b1);   // beq taken
      run_insn(6'h04, 6'h00, 1'b0, 0, 0, 1'b1);   // beq not taken
      chk("beq_retired", bus0.Retired, 32'd4);
      run_insn(6'h03, 6'h00, 1'b0, 0, 0, 1'b1);   // jal
      chk("jal_retired", bus0.Retired, 32'd5);
      run_insn(6'h3F, 6'h00, 1'b0, 0, 0, 1'b1);   // illegal
      chk("exc_retired_trap", bus0.Retired, 32'd5);
      chk("exc_retired_nop", {29'd0, bus1.Retired}, 32'd6);

      run_insn(6'h2B, 6'h00, 1'b0, 2, 1, 1'b0);   // sw, fetch and mem stalls
      run_insn(6'h05, 6'h00, 1'b0, 0, 0, 1'b1);   // bne taken
      run_insn(6'h05, 6'h00, 1'b1, 0, 0, 1'b0);   // bne not taken
      run_insn(6'h02, 6'h00, 1'b0, 0, 0, 1'b0);   // j
      run_insn(6'h00, 6'h08, 1'b0, 1, 0, 1'b1);   // jr
      run_insn(6'h00, 6'h09, 1'b0, 0, 0, 1'b0);   // jalr
      run_insn(6'h0D, 6'h00, 1'b0, 0, 0, 1'b0);   // ori
      run_insn(6'h3F, 6'h00, 1'b0, 0, 0, 1'b0);   // illegal
      run_insn(6'h23, 6'h00, 1'b0, 0, 0, 1'b0);   // lw, no stall
      run_insn(6'h00, 6'h22, 1'b0, 0, 0, 1'b1);   // sub
      chk("mix_retired_trap", bus0.Retired, 32'd14);
      chk("mix_retired_wrap", {29'd0, bus1.Retired}, 32'd0);

      // sw stalled in MEM, then reset asserted between clock edges.
      set_insn(6'h2B, 6'h00, 1'b0);
      f = '0; f.mem_req = 1; f.mem_read = 1; f.alu_src_b = 2'b01;
      f.ir_write = 1; f.pc_write = 1;
      cycle(1'b1, f, f, 0, 0);
      e = '0; e.alu_src_b = 2'b11;
      cycle(1'b1, e, e, 0, 0);
      e = '0; e.alu_src_a = 1; e.alu_src_b = 2'b10;
      cycle(1'b1, e, e, 0, 0);
      e = '0; e.mem_req = 1; e.iord = 1; e.mem_write = 1;
      cycle(1'b0, e, e, 0, 0);
      cycle(1'b0, e, e, 0, 0);
      chk_en = 1'b0;
      bus0.MemReady = 1'b0; bus1.MemReady = 1'b0;
      #1 chk("stall_memwrite_high", {31'd0, bus0.MemWrite}, 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("reset_memwrite_exc", {31'd0, bus0.MemWrite}, 32'd0);
      chk("reset_memwrite_nop", {31'd0, bus1.MemWrite}, 32'd0);
      chk("reset_memreq", {31'd0, bus0.MemReq}, 32'd0);
      chk("reset_retired_exc", bus0.Retired, 32'd0);
      chk("reset_retired_nop", {29'd0, bus1.Retired}, 32'd0);
      ret0 = 0;
      ret1 = 0;
      @(posedge clk);
      #1;
      cycle(1'b1, '0, '0, 0, 0);
      reset = 1'b0;
      run_insn(6'h00, 6'h20, 1'b0, 0, 0, 1'b1);   // add after reset
      chk("post_reset_retired", bus0.Retired, 32'd1);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
